// File: rtl/pxs_vga_sync.sv
// VGA raster timing generator emitting a registered PixelStream word with test patterns.
// Word layout (MSB..LSB): HS, VS, XC[9:0], YC[9:0], Active, RGB[2:0].
module pxs_vga_sync #(
   parameter int unsigned H_VIS    = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SW     = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_VIS    = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SW     = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic        px_clk,
   input  logic        reset,
   input  logic [1:0]  pattern_i,
   output logic [25:0] RGBStr_o,
   output logic        frame_start_o,
   output logic [7:0]  frame_cnt_o
);

   localparam int unsigned H_TOT = H_VIS + H_FP + H_SW + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SW + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0] H_ACTEND = 10'(H_VIS);
   localparam logic [9:0] V_ACTEND = 10'(V_VIS);
   localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SW);
   localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SW);

   typedef enum logic [1:0] {
      PAT_BLACK = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_WHITE = 2'd3
   } pattern_t;

   logic [9:0] hcnt;
   logic [9:0] vcnt;
   pattern_t   sel;
   logic       h_wrap;
   logic       frame_wrap;
   logic       active;
   logic       hs;
   logic       vs;
   logic [2:0] bar;
   logic [2:0] rgb;

   assign h_wrap     = (hcnt == H_LAST);
   assign frame_wrap = h_wrap && (vcnt == V_LAST);
   assign active     = (hcnt < H_ACTEND) && (vcnt < V_ACTEND);
   assign hs         = (hcnt >= HS_BEG && hcnt < HS_END) ? SYNC_POL : ~SYNC_POL;
   assign vs         = (vcnt >= VS_BEG && vcnt < VS_END) ? SYNC_POL : ~SYNC_POL;

   // Bar index = number of eighth-of-width boundaries already passed (ceil keeps it equal to hcnt*8/H_VIS).
   always_comb begin
      bar = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (hcnt >= 10'((k * H_VIS + 7) / 8)) bar = bar + 3'd1;
      end
   end

   always_comb begin
      rgb = '0;
      if (active) begin
         case (sel)
            PAT_BLACK: rgb = '0;
            PAT_BARS:  rgb = 3'd7 - bar;
            PAT_CHECK: rgb = (hcnt[5] ^ vcnt[5]) ? '1 : '0;
            PAT_WHITE: rgb = '1;
            default:   rgb = '0;
         endcase
      end
   end

   always_ff @(posedge px_clk) begin
      if (reset) begin
         hcnt          <= '0;
         vcnt          <= '0;
         sel           <= pattern_t'(pattern_i);
         frame_cnt_o   <= '0;
         frame_start_o <= 1'b0;
         RGBStr_o      <= {~SYNC_POL, ~SYNC_POL, 24'd0};
      end else begin
         RGBStr_o      <= {hs, vs, hcnt, vcnt, active, rgb};
         frame_start_o <= (hcnt == '0) && (vcnt == '0);
         if ((hcnt == '0) && (vcnt == '0)) frame_cnt_o <= frame_cnt_o + 8'd1;
         if (frame_wrap) sel <= pattern_t'(pattern_i);
         if (h_wrap) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
         end else begin
            hcnt <= hcnt + 10'd1;
         end
      end
   end

endmodule

// File: tb/tb_pxs_vga_sync.sv
// Scoreboard bench for pxs_vga_sync: a reduced raster instance with random patterns/resets,
// and a tiny raster instance run past 256 frames for the frame counter wrap.
module tb_pxs_vga_sync;

   typedef struct packed {
      int   hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
      logic pol;
   } timing_t;

   typedef struct {
      int pix;
      int sel;
      int frames;
   } model_t;

   typedef struct {
      logic [25:0] word;
      logic        fs;
      logic [7:0]  fc;
      logic        rst;
   } exp_t;

   localparam timing_t TM = '{hv: 64, hfp: 4, hsw: 8, hbp: 4, vv: 40, vfp: 2, vsw: 2, vbp: 4, pol: 1'b0};
   localparam timing_t TT = '{hv: 4, hfp: 1, hsw: 2, hbp: 1, vv: 3, vfp: 1, vsw: 1, vbp: 1, pol: 1'b1};
   localparam int M_HT = 80;
   localparam int M_FR = 80 * 48;
   localparam int T_FR = 8 * 6;

   logic        px_clk = 1'b0;
   logic        m_reset, t_reset;
   logic [1:0]  m_pat, t_pat;
   logic [25:0] m_rgb, t_rgb;
   logic        m_fs, t_fs;
   logic [7:0]  m_fc, t_fc;

   int     n_chk = 0;
   int     n_fail = 0;
   int     wraps = 0;
   bit     m_done = 0;
   bit     t_done = 0;
   exp_t   mq[$];
   exp_t   tq[$];
   model_t mm = '{0, 0, 0};
   model_t tm = '{0, 0, 0};

   always #5 px_clk = ~px_clk;

   pxs_vga_sync #(
      .H_VIS(64), .H_FP(4), .H_SW(8), .H_BP(4),
      .V_VIS(40), .V_FP(2), .V_SW(2), .V_BP(4),
      .SYNC_POL(1'b0)
   ) dut_main (
      .px_clk(px_clk), .reset(m_reset), .pattern_i(m_pat),
      .RGBStr_o(m_rgb), .frame_start_o(m_fs), .frame_cnt_o(m_fc)
   );

   pxs_vga_sync #(
      .H_VIS(4), .H_FP(1), .H_SW(2), .H_BP(1),
      .V_VIS(3), .V_FP(1), .V_SW(1), .V_BP(1),
      .SYNC_POL(1'b1)
   ) dut_tiny (
      .px_clk(px_clk), .reset(t_reset), .pattern_i(t_pat),
      .RGBStr_o(t_rgb), .frame_start_o(t_fs), .frame_cnt_o(t_fc)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference: raster position is simply (pixels since reset) folded by line and frame length.
   function automatic exp_t predict(input timing_t t, input logic rst, input logic [1:0] pat,
                                    inout model_t m);
      exp_t e;
      int   ht, vt, x, y, rgb;
      logic act, hs, vs;
      ht = t.hv + t.hfp + t.hsw + t.hbp;
      vt = t.vv + t.vfp + t.vsw + t.vbp;
      e.rst = rst;
      if (rst) begin
         e.word   = {~t.pol, ~t.pol, 24'd0};
         e.fs     = 1'b0;
         e.fc     = 8'd0;
         m.pix    = 0;
         m.sel    = int'(pat);
         m.frames = 0;
      end else begin
         x   = m.pix % ht;
         y   = (m.pix / ht) % vt;
         act = (x < t.hv) && (y < t.vv);
         hs  = (x >= t.hv + t.hfp && x < t.hv + t.hfp + t.hsw) ? t.pol : ~t.pol;
         vs  = (y >= t.vv + t.vfp && y < t.vv + t.vfp + t.vsw) ? t.pol : ~t.pol;
         rgb = 0;
         if (act) begin
            case (m.sel)
               1:       rgb = 7 - (x * 8) / t.hv;
               2:       rgb = (((x / 32) + (y / 32)) % 2 == 1) ? 7 : 0;
               3:       rgb = 7;
               default: rgb = 0;
            endcase
         end
         e.word = {hs, vs, 10'(x), 10'(y), act, 3'(rgb)};
         e.fs   = (x == 0 && y == 0);
         if (e.fs) m.frames = (m.frames + 1) % 256;
         e.fc = 8'(m.frames);
         if (x == ht - 1 && y == vt - 1) m.sel = int'(pat);
         m.pix++;
      end
      return e;
   endfunction

   task automatic m_step(input logic rst, input logic [1:0] pat);
      m_reset = rst;
      m_pat   = pat;
      mq.push_back(predict(TM, rst, pat, mm));
      @(negedge px_clk);
   endtask

   task automatic t_step(input logic rst, input logic [1:0] pat);
      t_reset = rst;
      t_pat   = pat;
      tq.push_back(predict(TT, rst, pat, tm));
      @(negedge px_clk);
   endtask

   // Main stimulus: bars, mid-frame switch to checkerboard, random patterns, directed and random resets.
   initial begin
      logic [1:0] pat;
      repeat (3) m_step(1'b1, 2'd1);
      while (mm.pix < 20 * M_HT) m_step(1'b0, 2'd1);
      while (mm.pix < 2 * M_FR) m_step(1'b0, 2'd2);
      pat = 2'd2;
      repeat (2 * M_FR) begin
         if ($urandom_range(0, 199) == 0) pat = 2'($urandom_range(0, 3));
         m_step(1'b0, pat);
      end
      while (mm.pix % M_FR != 20 * M_HT + 30) m_step(1'b0, pat);
      m_step(1'b1, 2'($urandom_range(0, 3)));
      repeat (M_FR + 500) begin
         if ($urandom_range(0, 49) == 0) pat = 2'($urandom_range(0, 3));
         m_step(1'b0 | ($urandom_range(0, 2999) == 0), pat);
      end
      m_done = 1;
      for (int i = 0; i < 20000 && !t_done; i++) @(negedge px_clk);
      check("tiny_stimulus_finished", 32'(t_done), 32'd1);
      repeat (3) @(negedge px_clk);
      check("main_queue_drained", mq.size(), 0);
      check("tiny_queue_drained", tq.size(), 0);
      check("tiny_frame_cnt_wraps", wraps, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      repeat (2) t_step(1'b1, 2'd1);
      repeat (258 * T_FR + 3) t_step(1'b0, 2'd1);
      t_done = 1;
   end

   initial begin
      exp_t e;
      int   act_n, hs_n, vs_n;
      bit   win;
      win = 0; act_n = 0; hs_n = 0; vs_n = 0;
      forever begin
         @(posedge px_clk);
         #1;
         if (mq.size() != 0) begin
            e = mq.pop_front();
            check("main_word", 32'(m_rgb), 32'(e.word));
            check("main_frame_start", 32'(m_fs), 32'(e.fs));
            check("main_frame_cnt", 32'(m_fc), 32'(e.fc));
            if (e.rst) begin
               win = 0;
            end else if (e.fs) begin
               if (win) begin
                  check("active_cycles_per_frame", act_n, TM.hv * TM.vv);
                  check("hs_cycles_per_frame", hs_n, TM.hsw * 48);
                  check("vs_cycles_per_frame", vs_n, TM.vsw * M_HT);
               end
               win = 1; act_n = 0; hs_n = 0; vs_n = 0;
            end
            if (win) begin
               act_n += int'(m_rgb[3]);
               hs_n  += int'(m_rgb[25] == TM.pol);
               vs_n  += int'(m_rgb[24] == TM.pol);
            end
         end else if (!m_done) begin
            check("main_expectation_present", 0, 1);
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge px_clk);
         #1;
         if (tq.size() != 0) begin
            e = tq.pop_front();
            check("tiny_word", 32'(t_rgb), 32'(e.word));
            check("tiny_frame_start", 32'(t_fs), 32'(e.fs));
            check("tiny_frame_cnt", 32'(t_fc), 32'(e.fc));
            if (t_fs === 1'b1 && t_fc === 8'd0) wraps++;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
